airlock_chamber: RTL and testbench

Behavioural responder for the airlock interlock controller. It accepts door and pump commands from the controller and models the chamber plant. Each command takes a fixed number of cycles to complete. The block then reports chamber pressure and door states back on a 4-bit status bus with the same bit layout as the controller's `q` output. It sits opposite the controller in the top-level bench and in the board build, replacing hand-driven switch stimulus.

---
 rtl/airlock_pkg.sv | 97 +++++++++
 rtl/delay_counter.sv | 38 +++
 rtl/airlock_chamber.sv | 118 +++++++++++
 tb/tb_airlock_chamber.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock chamber plant model: command codes,
// FSM states, status bit positions and the acceptance-time interlock check.
package airlock_pkg;

    localparam logic [2:0] CMD_PRESSURIZE  = 3'd1;
    localparam logic [2:0] CMD_EVACUATE    = 3'd2;
    localparam logic [2:0] CMD_OPEN_INNER  = 3'd3;
    localparam logic [2:0] CMD_CLOSE_INNER = 3'd4;
    localparam logic [2:0] CMD_OPEN_OUTER  = 3'd5;
    localparam logic [2:0] CMD_CLOSE_OUTER = 3'd6;

    // Bit positions in the status word {outer_open, inner_open, evacuated, pressurized}.
    localparam int Q_PRESS = 0;
    localparam int Q_EVAC  = 1;
    localparam int Q_INNER = 2;
    localparam int Q_OUTER = 3;

    // Pressurized, both doors closed.
    localparam logic [3:0] Q_RESET = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUMP = 2'd1,
        VENT = 2'd2,
        DOOR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        VERDICT_REJECT = 2'd0,
        VERDICT_NOOP   = 2'd1,
        VERDICT_START  = 2'd2
    } verdict_e;

    // Outcome of evaluating one command against the current chamber status.
    typedef struct packed {
        verdict_e   verdict;
        state_e     next_state;
        logic [3:0] target;     // status word to present once the operation completes
    } decision_t;

    // Interlock check first, then the redundancy check; a redundant command is a no-op.
    function automatic decision_t decide_cmd(input logic [2:0] cmd, input logic [3:0] q);
        decision_t  d;
        logic       doors_closed;
        doors_closed = !q[Q_INNER] && !q[Q_OUTER];
        d.verdict    = VERDICT_REJECT;
        d.next_state = IDLE;
        d.target     = q;
        case (cmd)
            CMD_PRESSURIZE: begin
                if (doors_closed) begin
                    d.verdict         = q[Q_PRESS] ? VERDICT_NOOP : VERDICT_START;
                    d.next_state      = PUMP;
                    d.target[Q_PRESS] = 1'b1;
                    d.target[Q_EVAC]  = 1'b0;
                end
            end
            CMD_EVACUATE: begin
                if (doors_closed) begin
                    d.verdict         = q[Q_EVAC] ? VERDICT_NOOP : VERDICT_START;
                    d.next_state      = VENT;
                    d.target[Q_PRESS] = 1'b0;
                    d.target[Q_EVAC]  = 1'b1;
                end
            end
            CMD_OPEN_INNER: begin
                if (q[Q_PRESS] && !q[Q_OUTER]) begin
                    d.verdict         = q[Q_INNER] ? VERDICT_NOOP : VERDICT_START;
                    d.next_state      = DOOR;
                    d.target[Q_INNER] = 1'b1;
                end
            end
            CMD_CLOSE_INNER: begin
                d.verdict         = q[Q_INNER] ? VERDICT_START : VERDICT_NOOP;
                d.next_state      = DOOR;
                d.target[Q_INNER] = 1'b0;
            end
            CMD_OPEN_OUTER: begin
                if (q[Q_EVAC] && !q[Q_INNER]) begin
                    d.verdict         = q[Q_OUTER] ? VERDICT_NOOP : VERDICT_START;
                    d.next_state      = DOOR;
                    d.target[Q_OUTER] = 1'b1;
                end
            end
            CMD_CLOSE_OUTER: begin
                d.verdict         = q[Q_OUTER] ? VERDICT_START : VERDICT_NOOP;
                d.next_state      = DOOR;
                d.target[Q_OUTER] = 1'b0;
            end
            default: begin
                d.verdict = VERDICT_REJECT;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/delay_counter.sv
// 4-bit loadable down-counter timing each chamber operation.
// Saturates at zero; never wraps.
module delay_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: load wins, otherwise decrement while enabled and non-zero.
    always_comb begin
        // NOTE: assign a default first so every path drives count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (!rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/airlock_chamber.sv
// Airlock chamber plant model: accepts controller commands, enforces the
// door/pressure interlocks, and reports status after a fixed operation delay.
module airlock_chamber
    import airlock_pkg::*;
#(
    parameter int PUMP_CYCLES = 8,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic [3:0] q,
    output logic       busy,
    output logic       rej
);

    // Counter preload so completion lands on the N-th edge after acceptance.
    localparam logic [3:0] PUMP_LOAD = 4'(PUMP_CYCLES - 1);
    localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] q_q, q_d;
    logic [3:0] tgt_q, tgt_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       rej_q, rej_d;

    logic       accept;
    decision_t  dec;
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       cnt_en;
    logic       cnt_zero;

    // ready_q is high exactly in IDLE, so this is the handshake.
    assign accept = cmd_valid && ready_q;
    assign dec    = decide_cmd(cmd, q_q);
    assign cnt_en = (state_q != IDLE);

    delay_counter u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Next-state, status and handshake logic.
    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        tgt_d        = tgt_q;
        busy_d       = busy_q;
        ready_d      = ready_q;
        rej_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = DOOR_LOAD;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (dec.verdict)
                        VERDICT_START: begin
                            state_d      = dec.next_state;
                            tgt_d        = dec.target;
                            busy_d       = 1'b1;
                            ready_d      = 1'b0;
                            cnt_load     = 1'b1;
                            cnt_load_val = (dec.next_state == DOOR) ? DOOR_LOAD : PUMP_LOAD;
                            // Chamber pressure is indeterminate while pumping or venting.
                            if (dec.next_state != DOOR) begin
                                q_d[Q_PRESS] = 1'b0;
                                q_d[Q_EVAC]  = 1'b0;
                            end
                        end
                        VERDICT_REJECT: rej_d = 1'b1;
                        default:        ;  // redundant command: accepted, nothing to do
                    endcase
                end
            end
            default: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    q_d     = tgt_q;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= Q_RESET;
            tgt_q   <= Q_RESET;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            rej_q   <= rej_d;
        end
    end

    assign cmd_ready = ready_q;
    assign q         = q_q;
    assign busy      = busy_q;
    assign rej       = rej_q;

endmodule

// File: tb/tb_airlock_chamber.sv
// Self-checking bench for airlock_chamber: directed vector table, two
// multi-cycle corner sequences, and a randomized run against a chamber model.
module tb_airlock_chamber;

    localparam int PUMP_N = 8;
    localparam int DOOR_N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic       cmd_ready;
    logic [3:0] q;
    logic       busy;
    logic       rej;

    always #5 clk = ~clk;

    airlock_chamber #(
        .PUMP_CYCLES (PUMP_N),
        .DOOR_CYCLES (DOOR_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .q         (q),
        .busy      (busy),
        .rej       (rej)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_q(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s q: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic eb, input logic er);
        check_q(tag, q, eq);
        check_bit({tag, " busy"}, busy, eb);
        check_bit({tag, " cmd_ready"}, cmd_ready, !eb);
        check_bit({tag, " rej"}, rej, er);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [3:0] eq;
        logic       eb;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [2:0] c, input logic [3:0] eq,
                                input logic eb, input logic er);
        vec_t t;
        t.v = v; t.c = c; t.eq = eq; t.eb = eb; t.er = er;
        tbl.push_back(t);
    endfunction

    function automatic void add_idle(input int n, input logic [3:0] eq, input logic eb);
        for (int i = 0; i < n; i++) add(1'b0, 3'd0, eq, eb, 1'b0);
    endfunction

    // ---------------- behavioural chamber model ----------------
    bit m_press, m_evac, m_inner, m_outer;
    int m_left;      // edges remaining until the pending operation completes
    int m_op;        // pending command code
    bit m_rej;

    function automatic logic [3:0] m_q();
        return {m_outer, m_inner, m_evac, m_press};
    endfunction

    task automatic model_reset();
        m_press = 1; m_evac = 0; m_inner = 0; m_outer = 0;
        m_left = 0; m_op = 0; m_rej = 0;
    endtask

    // Effect of one rising edge given the inputs sampled on it.
    task automatic model_edge(input bit v, input bit [2:0] c);
        bit ok, redundant;
        m_rej = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                case (m_op)
                    1: m_press = 1;
                    2: m_evac  = 1;
                    3: m_inner = 1;
                    4: m_inner = 0;
                    5: m_outer = 1;
                    6: m_outer = 0;
                    default: ;
                endcase
            end
        end else if (v) begin
            ok = 0;
            redundant = 0;
            case (c)
                1: begin ok = !m_inner && !m_outer; redundant = m_press; end
                2: begin ok = !m_inner && !m_outer; redundant = m_evac; end
                3: begin ok = m_press && !m_outer; redundant = m_inner; end
                4: begin ok = 1; redundant = !m_inner; end
                5: begin ok = m_evac && !m_inner; redundant = m_outer; end
                6: begin ok = 1; redundant = !m_outer; end
                default: ok = 0;
            endcase
            if (!ok) begin
                m_rej = 1;
            end else if (!redundant) begin
                m_op   = c;
                m_left = (c <= 3'd2) ? PUMP_N : DOOR_N;
                if (c <= 3'd2) begin
                    m_press = 0;
                    m_evac  = 0;
                end
            end
        end
    endtask

    initial begin
        bit last_idle;

        // ---- reset held, then released ----
        rst = 1'b0;
        tick();
        tick();
        check_all("in_reset", 4'b0001, 1'b0, 1'b0);
        rst = 1'b1;

        // ---- table: reset idle, doors, evacuate, refusals, redundant ----
        add_idle(5, 4'b0001, 1'b0);
        add(1, 3'd3, 4'b0001, 1, 0); add_idle(2, 4'b0001, 1'b1); add(0, 3'd0, 4'b0101, 0, 0);
        add(1, 3'd4, 4'b0101, 1, 0); add_idle(2, 4'b0101, 1'b1); add(0, 3'd0, 4'b0001, 0, 0);
        add(1, 3'd2, 4'b0000, 1, 0); add_idle(7, 4'b0000, 1'b1); add(0, 3'd0, 4'b0010, 0, 0);
        add(1, 3'd5, 4'b0010, 1, 0); add_idle(2, 4'b0010, 1'b1); add(0, 3'd0, 4'b1010, 0, 0);
        add(1, 3'd3, 4'b1010, 0, 1); add(0, 3'd0, 4'b1010, 0, 0);   // open inner while evacuated
        add(1, 3'd1, 4'b1010, 0, 1); add(0, 3'd0, 4'b1010, 0, 0);   // pressurize with outer open
        add(1, 3'd7, 4'b1010, 0, 1); add(0, 3'd0, 4'b1010, 0, 0);   // illegal code 7
        add(1, 3'd0, 4'b1010, 0, 1); add(0, 3'd0, 4'b1010, 0, 0);   // illegal code 0
        add(1, 3'd5, 4'b1010, 0, 0);                                // redundant open outer
        add(1, 3'd6, 4'b1010, 1, 0); add_idle(2, 4'b1010, 1'b1); add(0, 3'd0, 4'b0010, 0, 0);
        add(1, 3'd2, 4'b0010, 0, 0);                                // redundant evacuate
        add(1, 3'd7, 4'b0010, 0, 1); add(0, 3'd0, 4'b0010, 0, 0);
        add(1, 3'd1, 4'b0000, 1, 0); add_idle(7, 4'b0000, 1'b1); add(0, 3'd0, 4'b0001, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid = tbl[i].v;
            cmd       = tbl[i].c;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].er);
        end
        cmd_valid = 1'b0;

        // ---- held pressurize during an evacuate ----
        cmd_valid = 1'b1; cmd = 3'd2;
        tick();
        check_all("hold_evac_accept", 4'b0000, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd = 3'd1;
        for (int i = 2; i < PUMP_N; i++) tick();
        check_all("hold_evac_last_busy", 4'b0000, 1'b1, 1'b0);
        tick();
        check_all("hold_evac_done", 4'b0010, 1'b0, 1'b0);
        tick();
        check_all("hold_press_accept", 4'b0000, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 1; i < PUMP_N; i++) tick();
        check_all("hold_press_last_busy", 4'b0000, 1'b1, 1'b0);
        tick();
        check_all("hold_press_done", 4'b0001, 1'b0, 1'b0);

        // ---- asynchronous reset in the middle of a pressurize ----
        cmd_valid = 1'b1; cmd = 3'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < PUMP_N; i++) tick();
        check_all("abort_pre_evac", 4'b0010, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd = 3'd1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check_all("abort_mid_press", 4'b0000, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_all("abort_async", 4'b0001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        cmd_valid = 1'b1; cmd = 3'd3;
        tick();
        check_all("post_abort_accept", 4'b0001, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < DOOR_N; i++) tick();
        check_all("post_abort_done", 4'b0101, 1'b0, 1'b0);

        // ---- randomized run against the model ----
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd = 3'd0;
        tick();
        rst = 1'b1;
        model_reset();
        last_idle = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!cmd_valid || last_idle) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd       = 3'($urandom_range(0, 7));
            end
            last_idle = (m_left == 0);
            model_edge(cmd_valid, cmd);
            tick();
            check_all($sformatf("rnd%0d", i), m_q(), m_left > 0, m_rej);
            check_bit($sformatf("rnd%0d both_doors", i), q[3] & q[2], 1'b0);
            check_bit($sformatf("rnd%0d press_evac", i), q[1] & q[0], 1'b0);
        end
        cmd_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
